// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Request bundle, FSM state encoding and lane/latency limits.
package dmem_pkg;

  localparam int BYTE_LANES  = 4;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [BYTE_LANES-1:0] be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte-lane writes and a registered,
// resettable read port.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    IDX_W     = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  initial begin
    for (int j = 0; j < DEPTH; j++) mem[j] = '0;
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with fixed response latency.
// Define DMEM_RESP_STALL_EN to add LFSR-driven random wait states.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [BYTE_LANES-1:0] be,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e      state;
  dmem_req_t        cur;
  dmem_req_t        in_req;
  dmem_req_t        ram_req;
  logic [CNT_W-1:0] cnt;
  logic             stall;
  logic             accept;
  logic             fire_now;
  logic             fire_wait;
  logic             ram_en;

  assign in_req    = {we, 32'(addr), 32'(wdata), be};
  assign accept    = (state == IDLE) && req;
  assign fire_now  = accept && (LATENCY == 1) && !stall;
  assign fire_wait = (state == WAIT) && (cnt == CNT_W'(1)) && !stall;
  assign ram_en    = reset && (fire_now || fire_wait);
  assign ram_req   = (state == IDLE) ? in_req : cur;

`ifdef DMEM_RESP_STALL_EN
  logic [15:0] lfsr;
  logic [3:0]  scnt;
  logic        stall_ok;

  assign stall_ok = accept || (scnt != 4'd8);
  assign stall    = lfsr[0] && stall_ok &&
                    ((state == WAIT) || (accept && (LATENCY == 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
      scnt <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (accept) scnt <= {3'b0, stall};
      else if (stall) scnt <= scnt + 4'd1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            cur  <= in_req;
            busy <= 1'b1;
            if (fire_now) begin
              state <= RESP;
              done  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= (LATENCY == 1) ? CNT_W'(1) : CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (!stall) begin
            if (cnt == CNT_W'(1)) begin
              state <= RESP;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] ram_rdata;

  dmem_byte_ram #(
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .rst_n(reset),
    .en   (ram_en),
    .we   (ram_req.we),
    .be   (ram_req.be),
    .idx  (ram_req.addr[2 +: IDX_W]),
    .wdata(ram_req.wdata),
    .rdata(ram_rdata)
  );

  assign rdata = DATA_W'(ram_rdata);

endmodule
